// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter whose state advances through JK excitation; J/K are exported
// so an external JK flip-flop bank can track Q. Define JK_COUNTER_SAT_EN for saturating limits.
module jk_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             TC,
    output logic             WRAP
);

`ifdef JK_COUNTER_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] q_upd;

    assign at_max  = (Q == MAX_VAL);
    assign at_zero = (Q == '0);

    // Requested next state; out-of-range loads collapse to zero so Q stays in 0..MODULUS-1.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        nxt = Q;
        if (LOAD) begin
            nxt = (D <= MAX_VAL) ? D : '0;
        end else if (EN) begin
            if (UP) begin
                if (at_max) nxt = SAT_EN ? Q : '0;
                else        nxt = Q + ONE;
            end else begin
                if (at_zero) nxt = SAT_EN ? Q : MAX_VAL;
                else         nxt = Q - ONE;
            end
        end
    end

    // Excitation: set/reset form on load, toggle-where-different otherwise, J=0/K=Q under reset.
    always_comb begin
        J = '0;
        K = '0;
        if (RST) begin
            K = Q;
        end else if (LOAD) begin
            J = nxt;
            K = ~nxt;
        end else begin
            J = nxt ^ Q;
            K = nxt ^ Q;
        end
    end

    assign TC    = !RST && EN && !LOAD && ((UP && at_max) || (!UP && at_zero));
    assign q_upd = (J & ~Q) | (~K & Q);

    // Qbar is registered from the same update as Q rather than derived from Q.
    // NOTE: state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Q    <= '0;
            Qbar <= '1;
            WRAP <= 1'b0;
        end else begin
            Q    <= q_upd;
            Qbar <= ~q_upd;
            WRAP <= SAT_EN ? 1'b0 : TC;
        end
    end

endmodule
